// File: rtl/sa_tile_scheduler.sv
// sa_tile_scheduler
// Job-level sequencer for the systolic array engine. Accepts one matrix job
// (M x N grid of 8x8 output tiles), runs one engine pass per tile in raster
// order (n inner), answers the engine's DMA requests with read/write
// descriptors and reports completion or a watchdog/abort error.
//
// Ports:
//   clk, rstn                    clock, asynchronous active-low reset
//   job_valid / job_ready        job handshake (ready only in IDLE)
//   job_a/b/c_base               matrix base byte addresses
//   job_m_tiles / job_n_tiles    tile grid size
//   abort                        synchronous abort request
//   eng_start                    one-cycle engine start pulse
//   eng_rd_wr                    engine DMA request (2'b10 read, 2'b11 write)
//   eng_done                     engine done pulse
//   rd_desc_*                    read descriptor (addr, len in words)
//   wr_desc_*                    write descriptor (addr, len in words)
//   busy                         high outside IDLE
//   job_done / job_err           completion pulse / error qualifier
//   tiles_done                   tiles completed in the current job
module sa_tile_scheduler #(
  parameter int ADDR_W       = 32,
  parameter int CNT_W        = 8,
  parameter int A_TILE_BYTES = 64,
  parameter int B_TILE_BYTES = 64,
  parameter int C_TILE_BYTES = 256,
  parameter int TIMEOUT_CYC  = 65535
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 job_valid,
  output logic                 job_ready,
  input  logic [ADDR_W-1:0]    job_a_base,
  input  logic [ADDR_W-1:0]    job_b_base,
  input  logic [ADDR_W-1:0]    job_c_base,
  input  logic [CNT_W-1:0]     job_m_tiles,
  input  logic [CNT_W-1:0]     job_n_tiles,
  input  logic                 abort,
  output logic                 eng_start,
  input  logic [1:0]           eng_rd_wr,
  input  logic                 eng_done,
  output logic                 rd_desc_valid,
  input  logic                 rd_desc_ready,
  output logic [ADDR_W-1:0]    rd_desc_addr,
  output logic [15:0]          rd_desc_len,
  output logic                 wr_desc_valid,
  input  logic                 wr_desc_ready,
  output logic [ADDR_W-1:0]    wr_desc_addr,
  output logic [15:0]          wr_desc_len,
  output logic                 busy,
  output logic                 job_done,
  output logic                 job_err,
  output logic [2*CNT_W-1:0]   tiles_done
);

  localparam int WD_W = $clog2(TIMEOUT_CYC + 1);
  localparam logic [WD_W-1:0]    WD_LAST  = WD_W'(TIMEOUT_CYC - 1);
  localparam logic [WD_W-1:0]    WD_ONE   = WD_W'(1);
  localparam logic [ADDR_W-1:0]  A_STEP   = ADDR_W'(A_TILE_BYTES);
  localparam logic [ADDR_W-1:0]  B_STEP   = ADDR_W'(B_TILE_BYTES);
  localparam logic [ADDR_W-1:0]  C_STEP   = ADDR_W'(C_TILE_BYTES);
  localparam logic [CNT_W-1:0]   CNT_ZERO = '0;
  localparam logic [CNT_W-1:0]   CNT_ONE  = CNT_W'(1);
  localparam logic [2*CNT_W-1:0] TD_ONE   = (2*CNT_W)'(1);
  localparam logic [15:0]        AB_LEN   = 16'd16;
  localparam logic [15:0]        C_LEN    = 16'd64;
  localparam logic [1:0]         CODE_RD  = 2'b10;
  localparam logic [1:0]         CODE_WR  = 2'b11;

  typedef enum logic [3:0] {
    S_IDLE      = 4'd0,
    S_START     = 4'd1,
    S_WAIT_RD   = 4'd2,
    S_DESC_A    = 4'd3,
    S_DESC_B    = 4'd4,
    S_WAIT_WR   = 4'd5,
    S_DESC_C    = 4'd6,
    S_WAIT_DONE = 4'd7,
    S_NEXT      = 4'd8,
    S_FINISH    = 4'd9
  } state_t;

  state_t              state_r, state_nxt_s;
  logic [WD_W-1:0]     wd_r;
  logic                rd_req_r, wr_req_r, done_req_r;
  logic [ADDR_W-1:0]   a_addr_r, b_addr_r, c_addr_r, b_base_r;
  logic [CNT_W-1:0]    m_idx_r, n_idx_r, m_tiles_r, n_tiles_r;
  logic [2*CNT_W-1:0]  tiles_done_r;

  logic                accept_s, fin_err_s, wd_run_s, timeout_s;
  logic                use_rd_s, use_wr_s, use_done_s;
  logic                m_last_s, n_last_s;

  logic                job_ready_r, eng_start_r, busy_r, job_done_r, job_err_r;
  logic                rd_valid_r, wr_valid_r;
  logic [ADDR_W-1:0]   rd_addr_r, wr_addr_r;
  logic [15:0]         rd_len_r, wr_len_r;

  assign m_last_s  = (m_idx_r == (m_tiles_r - CNT_ONE));
  assign n_last_s  = (n_idx_r == (n_tiles_r - CNT_ONE));
  assign timeout_s = (wd_r == WD_LAST);

  // Next-state decode; abort overrides every non-IDLE state except FINISH.
  always_comb begin
    state_nxt_s = state_r;
    accept_s    = 1'b0;
    fin_err_s   = 1'b0;
    wd_run_s    = 1'b0;
    use_rd_s    = 1'b0;
    use_wr_s    = 1'b0;
    use_done_s  = 1'b0;
    case (state_r)
      S_IDLE: begin
        if (job_valid) begin
          accept_s = 1'b1;
          if ((job_m_tiles == CNT_ZERO) || (job_n_tiles == CNT_ZERO)) begin
            state_nxt_s = S_FINISH;
          end else begin
            state_nxt_s = S_START;
          end
        end else begin
          state_nxt_s = S_IDLE;
        end
      end
      S_START: state_nxt_s = S_WAIT_RD;
      S_WAIT_RD: begin
        wd_run_s = 1'b1;
        if (rd_req_r) begin
          use_rd_s    = 1'b1;
          state_nxt_s = S_DESC_A;
        end else if (timeout_s) begin
          fin_err_s   = 1'b1;
          state_nxt_s = S_FINISH;
        end else begin
          state_nxt_s = S_WAIT_RD;
        end
      end
      S_DESC_A, S_DESC_B: begin
        if (rd_desc_ready) begin
          state_nxt_s = (state_r == S_DESC_A) ? S_DESC_B : S_WAIT_WR;
        end else begin
          wd_run_s = 1'b1;
          if (timeout_s) begin
            fin_err_s   = 1'b1;
            state_nxt_s = S_FINISH;
          end else begin
            state_nxt_s = state_r;
          end
        end
      end
      S_WAIT_WR: begin
        wd_run_s = 1'b1;
        if (wr_req_r) begin
          use_wr_s    = 1'b1;
          state_nxt_s = S_DESC_C;
        end else if (timeout_s) begin
          fin_err_s   = 1'b1;
          state_nxt_s = S_FINISH;
        end else begin
          state_nxt_s = S_WAIT_WR;
        end
      end
      S_DESC_C: begin
        if (wr_desc_ready) begin
          state_nxt_s = S_WAIT_DONE;
        end else begin
          wd_run_s = 1'b1;
          if (timeout_s) begin
            fin_err_s   = 1'b1;
            state_nxt_s = S_FINISH;
          end else begin
            state_nxt_s = S_DESC_C;
          end
        end
      end
      S_WAIT_DONE: begin
        wd_run_s = 1'b1;
        if (done_req_r) begin
          use_done_s  = 1'b1;
          state_nxt_s = S_NEXT;
        end else if (timeout_s) begin
          fin_err_s   = 1'b1;
          state_nxt_s = S_FINISH;
        end else begin
          state_nxt_s = S_WAIT_DONE;
        end
      end
      S_NEXT: begin
        if (m_last_s && n_last_s) begin
          state_nxt_s = S_FINISH;
        end else begin
          state_nxt_s = S_START;
        end
      end
      S_FINISH: state_nxt_s = S_IDLE;
      default:  state_nxt_s = S_IDLE;
    endcase
    // Abort wins over any handshake in the same cycle.
    if (abort && (state_r != S_IDLE) && (state_r != S_FINISH)) begin
      state_nxt_s = S_FINISH;
      fin_err_s   = 1'b1;
    end else begin
      fin_err_s   = fin_err_s;
    end
  end

  // State register and per-state watchdog counter.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_r <= S_IDLE;
      wd_r    <= '0;
    end else begin
      state_r <= state_nxt_s;
      if (state_nxt_s != state_r) begin
        wd_r <= '0;
      end else if (wd_run_s) begin
        wd_r <= wd_r + WD_ONE;
      end else begin
        wd_r <= wd_r;
      end
    end
  end

  // Sticky engine request/done flags; a fresh request beats consumption.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rd_req_r   <= 1'b0;
      wr_req_r   <= 1'b0;
      done_req_r <= 1'b0;
    end else if (state_r == S_IDLE) begin
      rd_req_r   <= 1'b0;
      wr_req_r   <= 1'b0;
      done_req_r <= 1'b0;
    end else begin
      rd_req_r   <= (eng_rd_wr == CODE_RD) | (rd_req_r & ~use_rd_s);
      wr_req_r   <= (eng_rd_wr == CODE_WR) | (wr_req_r & ~use_wr_s);
      done_req_r <= eng_done | (done_req_r & ~use_done_s);
    end
  end

  // Job registers, tile indices and address walkers (adders only).
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      a_addr_r     <= '0;
      b_addr_r     <= '0;
      c_addr_r     <= '0;
      b_base_r     <= '0;
      m_idx_r      <= '0;
      n_idx_r      <= '0;
      m_tiles_r    <= '0;
      n_tiles_r    <= '0;
      tiles_done_r <= '0;
    end else if (accept_s) begin
      a_addr_r     <= job_a_base;
      b_addr_r     <= job_b_base;
      c_addr_r     <= job_c_base;
      b_base_r     <= job_b_base;
      m_idx_r      <= '0;
      n_idx_r      <= '0;
      m_tiles_r    <= job_m_tiles;
      n_tiles_r    <= job_n_tiles;
      tiles_done_r <= '0;
    end else if (state_r == S_NEXT) begin
      tiles_done_r <= tiles_done_r + TD_ONE;
      c_addr_r     <= c_addr_r + C_STEP;
      if (!n_last_s) begin
        n_idx_r  <= n_idx_r + CNT_ONE;
        b_addr_r <= b_addr_r + B_STEP;
      end else begin
        n_idx_r  <= '0;
        b_addr_r <= b_base_r;
        m_idx_r  <= m_idx_r + CNT_ONE;
        a_addr_r <= a_addr_r + A_STEP;
      end
    end else begin
      tiles_done_r <= tiles_done_r;
    end
  end

  // Outputs registered from the next state so they line up with state_r.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      job_ready_r <= 1'b1;
      eng_start_r <= 1'b0;
      busy_r      <= 1'b0;
      job_done_r  <= 1'b0;
      job_err_r   <= 1'b0;
      rd_valid_r  <= 1'b0;
      rd_addr_r   <= '0;
      rd_len_r    <= 16'd0;
      wr_valid_r  <= 1'b0;
      wr_addr_r   <= '0;
      wr_len_r    <= 16'd0;
    end else begin
      job_ready_r <= (state_nxt_s == S_IDLE);
      eng_start_r <= (state_nxt_s == S_START);
      busy_r      <= (state_nxt_s != S_IDLE);
      job_done_r  <= (state_nxt_s == S_FINISH);
      job_err_r   <= (state_nxt_s == S_FINISH) && fin_err_s;
      if (state_nxt_s == S_DESC_A) begin
        rd_valid_r <= 1'b1;
        rd_addr_r  <= a_addr_r;
        rd_len_r   <= AB_LEN;
      end else if (state_nxt_s == S_DESC_B) begin
        rd_valid_r <= 1'b1;
        rd_addr_r  <= b_addr_r;
        rd_len_r   <= AB_LEN;
      end else begin
        rd_valid_r <= 1'b0;
        rd_addr_r  <= '0;
        rd_len_r   <= 16'd0;
      end
      if (state_nxt_s == S_DESC_C) begin
        wr_valid_r <= 1'b1;
        wr_addr_r  <= c_addr_r;
        wr_len_r   <= C_LEN;
      end else begin
        wr_valid_r <= 1'b0;
        wr_addr_r  <= '0;
        wr_len_r   <= 16'd0;
      end
    end
  end

  assign job_ready     = job_ready_r;
  assign eng_start     = eng_start_r;
  assign busy          = busy_r;
  assign job_done      = job_done_r;
  assign job_err       = job_err_r;
  assign rd_desc_valid = rd_valid_r;
  assign rd_desc_addr  = rd_addr_r;
  assign rd_desc_len   = rd_len_r;
  assign wr_desc_valid = wr_valid_r;
  assign wr_desc_addr  = wr_addr_r;
  assign wr_desc_len   = wr_len_r;
  assign tiles_done    = tiles_done_r;

endmodule
